logic_anlz: RTL and testbench

- Single-clock logic analyzer. Samples the 24-bit user probe bus every axi_clk, masks it, and run-length compresses it into 32-bit trace words {run_count[7:0], data[23:0]}.
- Trace words are buffered in a FIFO and streamed on an AXI-Stream master toward the upstream host; a high-priority request flag signals FIFO fill level.
- Configured through a small AXI-Lite slave register bank.

---
 rtl/logic_anlz_pkg.sv | 34 +++
 rtl/logic_anlz_fifo.sv | 52 +++++
 rtl/logic_anlz.sv | 210 +++++++++++++++++++++
 tb/tb_logic_anlz.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_anlz_pkg.sv
// Shared types and constants for the logic analyzer.
// Register map, reset values and trace-word layout.
package logic_anlz_pkg;

  localparam int DATA_W = 24;
  localparam int CNT_W  = 8;
  localparam int WORD_W = 32;
  localparam int THR_W  = 7;

  localparam logic [CNT_W-1:0] MAX_RUN = 8'd255;

  localparam logic [2:0]  REG_PAGE = 3'b001;
  localparam logic [11:0] OFF_MASK = 12'h000;
  localparam logic [11:0] OFF_HTH  = 12'h004;
  localparam logic [11:0] OFF_LTH  = 12'h008;
  localparam logic [11:0] OFF_POP  = 12'h00C;
  localparam logic [11:0] OFF_EN   = 12'h010;
  localparam logic [11:0] OFF_STAT = 12'h014;

  localparam logic [THR_W-1:0] RST_HTH = 7'h3F;
  localparam logic [THR_W-1:0] RST_LTH = 7'h3F;
  localparam logic [THR_W-1:0] RST_POP = 7'h01;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } strm_e;

  typedef struct packed {
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] data;
  } trace_t;

endpackage

// File: rtl/logic_anlz_fifo.sv
// Trace FIFO with occupancy count.
// Pushes into a full FIFO are discarded.
module logic_anlz_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/logic_anlz.sv
// Logic analyzer: masked probe capture, run-length
// trace words, FIFO, AXI-Stream out, AXI-Lite config.
module logic_anlz
  import logic_anlz_pkg::*;
#(
  parameter int pADDR_WIDTH = 15,
  parameter int pDATA_WIDTH = 32,
  parameter int pFIFO_DEPTH = 64
) (
  input  logic                   axi_clk,
  input  logic                   axi_reset_n,
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   user_clock2,
  input  logic                   uck2_rst_n,
  input  logic                   cc_la_enable,
  input  logic                   axi_awvalid,
  output logic                   axi_awready,
  input  logic [pADDR_WIDTH-1:0] axi_awaddr,
  input  logic                   axi_wvalid,
  output logic                   axi_wready,
  input  logic [pDATA_WIDTH-1:0] axi_wdata,
  input  logic [3:0]             axi_wstrb,
  input  logic                   axi_arvalid,
  output logic                   axi_arready,
  input  logic [pADDR_WIDTH-1:0] axi_araddr,
  output logic                   axi_rvalid,
  input  logic                   axi_rready,
  output logic [pDATA_WIDTH-1:0] axi_rdata,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [3:0]             m_tstrb,
  output logic [3:0]             m_tkeep,
  output logic                   m_tlast,
  output logic [1:0]             m_tuser,
  output logic                   la_hpri_req,
  input  logic [DATA_W-1:0]      up_la_data
);

  localparam int CW = $clog2(pFIFO_DEPTH) + 1;

  logic [DATA_W-1:0]      mask;
  logic [THR_W-1:0]       hth;
  logic [THR_W-1:0]       lth;
  logic [THR_W-1:0]       pop_cond;
  logic                   en;
  logic                   ovf;
  logic                   wr_go;
  logic                   wr_hit;
  logic [11:0]            wofs;
  logic                   rd_go;
  logic [pADDR_WIDTH-1:0] rd_addr;
  logic [pDATA_WIDTH-1:0] rd_word;
  trace_t                 run;
  logic                   run_valid;
  logic                   active;
  logic [DATA_W-1:0]      smp;
  logic                   push;
  logic                   pop;
  logic [WORD_W-1:0]      head;
  logic [CW-1:0]          count;
  logic                   full;
  logic                   empty;
  strm_e                  state;
  strm_e                  state_nx;
  logic                   unused_ok;

  assign unused_ok = &{1'b0, axis_clk, axis_rst_n, user_clock2,
                       uck2_rst_n, axi_wstrb, axi_wdata[31:24]};

  assign wr_go  = axi_awvalid && axi_wvalid && cc_la_enable
                  && !axi_awready;
  assign wr_hit = wr_go && axi_awaddr[14:12] == REG_PAGE;
  assign wofs   = axi_awaddr[11:0];
  assign rd_go  = axi_arvalid && !axi_rvalid && !axi_arready
                  && cc_la_enable;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      mask     <= '0;
      hth      <= RST_HTH;
      lth      <= RST_LTH;
      pop_cond <= RST_POP;
      en       <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (wr_hit) begin
        unique case (1'b1)
          wofs == OFF_MASK: mask     <= axi_wdata[DATA_W-1:0];
          wofs == OFF_HTH:  hth      <= axi_wdata[THR_W-1:0];
          wofs == OFF_LTH:  lth      <= axi_wdata[THR_W-1:0];
          wofs == OFF_POP:  pop_cond <= axi_wdata[THR_W-1:0];
          wofs == OFF_EN:   en       <= axi_wdata[0];
          default: ;
        endcase
      end
      // A drop in the same cycle as a clear keeps the flag set
      if (push && full)
        ovf <= 1'b1;
      else if (wr_hit && wofs == OFF_STAT)
        ovf <= 1'b0;
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_addr[14:12] == REG_PAGE) begin
      unique case (1'b1)
        rd_addr[11:0] == OFF_MASK: rd_word = pDATA_WIDTH'(mask);
        rd_addr[11:0] == OFF_HTH:  rd_word = pDATA_WIDTH'(hth);
        rd_addr[11:0] == OFF_LTH:  rd_word = pDATA_WIDTH'(lth);
        rd_addr[11:0] == OFF_POP:  rd_word = pDATA_WIDTH'(pop_cond);
        rd_addr[11:0] == OFF_EN:   rd_word = pDATA_WIDTH'(en);
        rd_addr[11:0] == OFF_STAT:
          rd_word = pDATA_WIDTH'({ovf, 1'b0, count});
        default: ;
      endcase
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      axi_awready <= 1'b0;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rdata   <= '0;
      rd_addr     <= '0;
    end else begin
      axi_awready <= wr_go;
      axi_arready <= rd_go;
      if (rd_go) rd_addr <= axi_araddr;
      if (axi_arready) begin
        axi_rvalid <= 1'b1;
        axi_rdata  <= rd_word;
      end else if (axi_rvalid && axi_rready) begin
        axi_rvalid <= 1'b0;
        axi_rdata  <= '0;
      end
    end
  end

  assign axi_wready = axi_awready;

  assign active = en && cc_la_enable;
  assign smp    = up_la_data & mask;
  assign push   = run_valid && (!active || smp != run.data
                                || run.cnt == MAX_RUN);

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      run       <= '0;
      run_valid <= 1'b0;
    end else if (!active) begin
      run_valid <= 1'b0;
    end else begin
      run_valid <= 1'b1;
      if (!run_valid || push)
        run <= '{cnt: CNT_W'(1), data: smp};
      else
        run.cnt <= run.cnt + CNT_W'(1);
    end
  end

  logic_anlz_fifo #(
    .DEPTH (pFIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (axi_clk),
    .rst_n (axi_reset_n),
    .push  (push),
    .din   (run),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) state <= ST_IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (count >= CW'(pop_cond)) state_nx = ST_STREAM;
      ST_STREAM: if (empty) state_nx = ST_IDLE;
    endcase
  end

  assign pop      = m_tvalid && m_tready;
  assign m_tvalid = state == ST_STREAM && !empty;
  assign m_tdata  = empty ? '0 : pDATA_WIDTH'(head);
  assign m_tlast  = count == CW'(1);
  assign m_tstrb  = 4'hF;
  assign m_tkeep  = 4'hF;
  assign m_tuser  = 2'b00;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n)
      la_hpri_req <= 1'b0;
    else if (count >= CW'(hth))
      la_hpri_req <= 1'b1;
    else if (count < CW'(lth))
      la_hpri_req <= 1'b0;
  end

endmodule

// File: tb/tb_logic_anlz.sv
// Bench for logic_anlz: run-length trace model with a
// queue-based FIFO scoreboard and AXI-Lite register shadows.
module tb_logic_anlz;

  logic        axi_clk = 1'b0;
  logic        axi_reset_n = 1'b0;
  logic        cc_la_enable = 1'b1;
  logic        user_clock2 = 1'b0;
  logic        uck2_rst_n = 1'b0;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [14:0] axi_awaddr = '0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [14:0] axi_araddr = '0;
  logic        axi_rvalid;
  logic        axi_rready = 1'b0;
  logic [31:0] axi_rdata;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [3:0]  m_tstrb;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic [1:0]  m_tuser;
  logic        la_hpri_req;
  logic [23:0] up_la_data = '0;

  always #5 axi_clk = ~axi_clk;

  logic_anlz dut (
    .axi_clk      (axi_clk),
    .axi_reset_n  (axi_reset_n),
    .axis_clk     (axi_clk),
    .axis_rst_n   (axi_reset_n),
    .user_clock2  (user_clock2),
    .uck2_rst_n   (uck2_rst_n),
    .cc_la_enable (cc_la_enable),
    .axi_awvalid  (axi_awvalid),
    .axi_awready  (axi_awready),
    .axi_awaddr   (axi_awaddr),
    .axi_wvalid   (axi_wvalid),
    .axi_wready   (axi_wready),
    .axi_wdata    (axi_wdata),
    .axi_wstrb    (axi_wstrb),
    .axi_arvalid  (axi_arvalid),
    .axi_arready  (axi_arready),
    .axi_araddr   (axi_araddr),
    .axi_rvalid   (axi_rvalid),
    .axi_rready   (axi_rready),
    .axi_rdata    (axi_rdata),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tstrb      (m_tstrb),
    .m_tkeep      (m_tkeep),
    .m_tlast      (m_tlast),
    .m_tuser      (m_tuser),
    .la_hpri_req  (la_hpri_req),
    .up_la_data   (up_la_data)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] q[$];
  logic [31:0] seen[$];
  logic [23:0] m_mask;
  logic [6:0]  m_hth, m_lth, m_pop;
  logic        m_en, m_ovf, hm;
  logic        r_valid;
  logic [23:0] r_cur;
  int          r_cnt;
  logic        last_tlast;

  task automatic model_reset();
    q.delete();
    r_valid = 1'b0;
    r_cur = '0;
    r_cnt = 0;
    m_mask = '0;
    m_hth = 7'h3F;
    m_lth = 7'h3F;
    m_pop = 7'h01;
    m_en = 1'b0;
    m_ovf = 1'b0;
    hm = 1'b0;
  endtask

  function automatic void shadow_write(input logic [31:0] a,
                                       input logic [31:0] d);
    if (a[14:12] == 3'b001) begin
      case (a[11:0])
        12'h000: m_mask = d[23:0];
        12'h004: m_hth = d[6:0];
        12'h008: m_lth = d[6:0];
        12'h00C: m_pop = d[6:0];
        12'h010: m_en = d[0];
        12'h014: m_ovf = 1'b0;
        default: ;
      endcase
    end
  endfunction

  // One clock: check, advance the model across the edge, return at negedge
  task automatic cycle();
    logic        hs;
    logic [31:0] obs, pw, expv;
    logic [23:0] s;
    logic        push;
    int          pre;
    n_vec++;
    if (m_tlast !== (q.size() == 1)) begin
      n_err++;
      $display("FAIL tlast: got %b expected %b", m_tlast, q.size() == 1);
    end
    n_vec++;
    if (la_hpri_req !== hm) begin
      n_err++;
      $display("FAIL hpri: got %b expected %b", la_hpri_req, hm);
    end
    n_vec++;
    if (m_tvalid === 1'b1 && q.size() == 0) begin
      n_err++;
      $display("FAIL tvalid_empty: got 1 expected 0");
    end
    hs = m_tvalid & m_tready;
    obs = m_tdata;
    s = up_la_data & m_mask;
    push = 1'b0;
    pw = '0;
    if (m_en && cc_la_enable) begin
      if (r_valid && s == r_cur && r_cnt < 255) begin
        r_cnt++;
      end else begin
        if (r_valid) begin
          push = 1'b1;
          pw = {8'(r_cnt), r_cur};
        end
        r_cur = s;
        r_cnt = 1;
        r_valid = 1'b1;
      end
    end else if (r_valid) begin
      push = 1'b1;
      pw = {8'(r_cnt), r_cur};
      r_valid = 1'b0;
    end
    pre = q.size();
    if (pre >= int'(m_hth)) hm = 1'b1;
    else if (pre < int'(m_lth)) hm = 1'b0;
    if (hs === 1'b1) begin
      expv = (q.size() > 0) ? q[0] : 32'h0;
      n_vec++;
      if (q.size() == 0 || obs !== expv) begin
        n_err++;
        $display("FAIL stream_word: got %h expected %h", obs, expv);
      end
      seen.push_back(obs);
      last_tlast = m_tlast;
      if (q.size() > 0) void'(q.pop_front());
    end
    if (push) begin
      if (pre < 64) q.push_back(pw);
      else m_ovf = 1'b1;
    end
    @(posedge axi_clk);
    @(negedge axi_clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    int pulses = 0;
    bit got = 0;
    axi_awaddr = a[14:0];
    axi_wdata = d;
    axi_wstrb = 4'h0;
    axi_awvalid = 1'b1;
    axi_wvalid = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      if (axi_awready === 1'b1) begin
        got = 1;
        pulses++;
        shadow_write(a, d);
        n_vec++;
        if (axi_wready !== 1'b1) begin
          n_err++;
          $display("FAIL wready: got %b expected 1", axi_wready);
        end
      end
    end
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (axi_awready === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL aw_pulse %h: got %0d expected 1", a, pulses);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                    input string nm);
    bit got = 0;
    axi_araddr = a[14:0];
    axi_arvalid = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      got = (axi_arready === 1'b1);
    end
    axi_arvalid = 1'b0;
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL %s arready: got 0 expected 1", nm);
    end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      got = (axi_rvalid === 1'b1);
    end
    n_vec++;
    if (!got || axi_rdata !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, axi_rdata, exp);
    end
    cycle();
    n_vec++;
    if (axi_rvalid !== 1'b1 || axi_rdata !== exp) begin
      n_err++;
      $display("FAIL %s hold: got %b/%h expected 1/%h",
               nm, axi_rvalid, axi_rdata, exp);
    end
    axi_rready = 1'b1;
    cycle();
    axi_rready = 1'b0;
    n_vec++;
    if (axi_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL %s rvalid_clear: got %b expected 0", nm, axi_rvalid);
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if ({axi_awready, axi_wready, axi_arready, axi_rvalid,
         m_tvalid, m_tlast, la_hpri_req} !== 7'b0) begin
      n_err++;
      $display("FAIL ctl_reset: got %b%b%b%b%b%b%b expected 0",
               axi_awready, axi_wready, axi_arready, axi_rvalid,
               m_tvalid, m_tlast, la_hpri_req);
    end
    n_vec++;
    if (axi_rdata !== 32'h0 || m_tdata !== 32'h0) begin
      n_err++;
      $display("FAIL data_reset: got %h/%h expected 0/0",
               axi_rdata, m_tdata);
    end
    n_vec++;
    if ({m_tstrb, m_tkeep, m_tuser} !== {4'hF, 4'hF, 2'b00}) begin
      n_err++;
      $display("FAIL side_const: got %h %h %b expected f f 00",
               m_tstrb, m_tkeep, m_tuser);
    end
    axi_reset_n = 1'b1;
    @(negedge axi_clk);
    rd(32'h30001000, 32'h0, "rst_mask");
    rd(32'h30001004, 32'h3F, "rst_hth");
    rd(32'h30001008, 32'h3F, "rst_lth");
    rd(32'h3000100C, 32'h01, "rst_pop");
    rd(32'h30001010, 32'h0, "rst_en");
    rd(32'h30001014, 32'h0, "rst_status");
  endtask

  task automatic test_write_read();
    int pulses = 0;
    wr(32'h30001000, 32'hFFFFFFFF);
    rd(32'h30001000, 32'h00FFFFFF, "mask_rb");
    wr(32'h30002000, 32'h0);
    rd(32'h30001000, 32'h00FFFFFF, "mask_after_bad_page");
    rd(32'h30002000, 32'h0, "bad_page_rd");
    rd(32'h30001018, 32'h0, "undecoded_rd");
    cc_la_enable = 1'b0;
    axi_awaddr = 15'h1000;
    axi_wdata = 32'h0;
    axi_awvalid = 1'b1;
    axi_wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (axi_awready === 1'b1) pulses++;
    end
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b0;
    cc_la_enable = 1'b1;
    n_vec++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL gated_write: got %0d expected 0", pulses);
    end
    rd(32'h30001000, 32'h00FFFFFF, "mask_after_gate");
  endtask

  task automatic test_fill();
    wr(32'h3000100C, 32'h3F);
    up_la_data = 24'h0;
    wr(32'h30001010, 32'h1);
    for (int n = 0; n < 200; n++) begin
      up_la_data = 24'(n);
      cycle();
    end
    n_vec++;
    if (la_hpri_req !== 1'b1) begin
      n_err++;
      $display("FAIL hpri_full: got %b expected 1", la_hpri_req);
    end
    wr(32'h30001010, 32'h0);
    repeat (3) cycle();
    rd(32'h30001014, 32'h00000140, "status_full");
    wr(32'h30001014, 32'h0);
    rd(32'h30001014, 32'h00000040, "status_ovf_clr");
  endtask

  task automatic test_drain();
    seen.delete();
    last_tlast = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 300 && (q.size() > 0 || m_tvalid); i++)
      cycle();
    n_vec++;
    if (q.size() != 0 || seen.size() != 64) begin
      n_err++;
      $display("FAIL drain: got %0d words expected 64", seen.size());
    end
    n_vec++;
    if (seen.size() == 64 && (seen[5] !== 32'h01000005 ||
                              seen[63] !== 32'h0100003F)) begin
      n_err++;
      $display("FAIL drain_words: got %h %h expected 01000005 0100003f",
               seen[5], seen[63]);
    end
    n_vec++;
    if (last_tlast !== 1'b1 || la_hpri_req !== 1'b0) begin
      n_err++;
      $display("FAIL drain_end: got tlast %b hpri %b expected 1 0",
               last_tlast, la_hpri_req);
    end
    rd(32'h30001014, 32'h0, "status_empty");
  endtask

  task automatic test_runlen();
    int k = -1;
    wr(32'h3000100C, 32'h1);
    up_la_data = 24'h0;
    wr(32'h30001010, 32'h1);
    repeat (5) cycle();
    seen.delete();
    up_la_data = 24'hABCDEF;
    repeat (300) cycle();
    up_la_data = 24'h123456;
    repeat (5) cycle();
    cc_la_enable = 1'b0;
    repeat (10) cycle();
    for (int i = 0; i + 1 < seen.size(); i++)
      if (k < 0 && seen[i] === 32'hFFABCDEF) k = i;
    n_vec++;
    if (k < 0 || seen[k+1] !== 32'h2DABCDEF) begin
      n_err++;
      $display("FAIL run_split: got idx %0d expected ff/2d pair", k);
    end
    cc_la_enable = 1'b1;
  endtask

  task automatic test_mask();
    int nm = 0;
    int cnt = 0;
    logic [15:0] r;
    seen.delete();
    up_la_data = {16'h1234, 8'h5A};
    wr(32'h30001000, 32'h000000FF);
    for (int i = 0; i < 20; i++) begin
      r = 16'($urandom);
      up_la_data = {r, 8'h5A};
      cycle();
    end
    cc_la_enable = 1'b0;
    repeat (10) cycle();
    foreach (seen[i])
      if (seen[i][23:0] === 24'h00005A) begin
        nm++;
        cnt = int'(seen[i][31:24]);
      end
    n_vec++;
    if (nm != 1 || cnt < 20) begin
      n_err++;
      $display("FAIL mask_run: got %0d words cnt %0d expected 1 >=20",
               nm, cnt);
    end
    cc_la_enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [23:0] r;
    bit got = 0;
    m_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      r = 24'($urandom);
      up_la_data = r;
      cycle();
    end
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      got = (m_tvalid === 1'b1);
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL pre_reset_tvalid: got 0 expected 1");
    end
    axi_reset_n = 1'b0;
    #1;
    n_vec++;
    if ({m_tvalid, m_tlast, la_hpri_req} !== 3'b0 ||
        m_tdata !== 32'h0) begin
      n_err++;
      $display("FAIL mid_reset: got %b%b%b %h expected 000 0",
               m_tvalid, m_tlast, la_hpri_req, m_tdata);
    end
    model_reset();
    @(posedge axi_clk);
    @(negedge axi_clk);
    axi_reset_n = 1'b1;
    @(negedge axi_clk);
    rd(32'h30001014, 32'h0, "status_after_reset");
    rd(32'h30001010, 32'h0, "en_after_reset");
    rd(32'h30001000, 32'h0, "mask_after_reset");
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    last_tlast = 1'b0;
    repeat (3) @(negedge axi_clk);
    test_reset();
    test_write_read();
    test_fill();
    test_drain();
    test_runlen();
    test_mask();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
